// File: rtl/audio_sample_packetizer.sv
// Packs 2-channel PCM frames into HDMI Audio Sample Packets (layout 0), adding the
// IEC 60958 V/U/C/P bits and the 192-frame block-start flags.
module audio_sample_packetizer #(
  parameter int BIT_WIDTH          = 16,
  parameter int SAMPLES_PER_PACKET = 4
) (
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  input  logic [BIT_WIDTH-1:0] audio_sample [2],
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic                 flush,
  input  logic [191:0]         channel_status,
  output logic [23:0]          header,
  output logic [55:0]          sub [4],
  output logic                 packet_valid,
  input  logic                 packet_ready
);

  typedef enum logic {COLLECT, ISSUE} state_t;

  localparam logic [2:0] SPP = 3'(SAMPLES_PER_PACKET);

  state_t         state_reg, state_next;
  logic [2:0]     count_reg, count_next;
  logic [7:0]     frame_index_reg;
  logic [191:0]   cs_reg;
  logic           accept, consume, block_start, c_bit;
  logic [23:0]    field [2];
  logic [1:0]     parity;
  logic [55:0]    new_sub;
  logic [3:0]     present_vec, b_vec;

  assign packet_valid = (state_reg == ISSUE);
  assign sample_ready = reset_n && !packet_valid;
  assign accept       = sample_valid && sample_ready;
  assign consume      = packet_valid && packet_ready;
  assign count_next   = count_reg + {2'b00, accept};

  // Frame 0 of a block uses the live status word; later frames use the copy taken then
  assign block_start = (frame_index_reg == 8'd0);
  assign c_bit       = block_start ? channel_status[0] : cs_reg[frame_index_reg];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign field[gi]  = 24'(audio_sample[gi]) << (24 - BIT_WIDTH);
      assign parity[gi] = (^field[gi]) ^ c_bit;
    end
  endgenerate

  assign new_sub = {parity[1], c_bit, 2'b00, parity[0], c_bit, 2'b00, field[1], field[0]};

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: begin
        if ((accept && count_next == SPP) || (flush && count_next != 3'd0)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (packet_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      count_reg       <= 3'd0;
      frame_index_reg <= 8'd0;
      cs_reg          <= '0;
    end else begin
      if (consume) begin
        count_reg <= 3'd0;
      end else if (accept) begin
        count_reg <= count_next;
      end
      if (accept) begin
        frame_index_reg <= (frame_index_reg == 8'd191) ? 8'd0 : frame_index_reg + 8'd1;
        if (block_start) begin
          cs_reg <= channel_status;
        end
      end
    end
  end

  // One register set per subpacket slot; slot k is written by the frame accepted at count k
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      logic [55:0] data_reg;
      logic        present_reg;
      logic        b_reg;

      always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
          data_reg    <= '0;
          present_reg <= 1'b0;
          b_reg       <= 1'b0;
        end else if (consume) begin
          data_reg    <= '0;
          present_reg <= 1'b0;
          b_reg       <= 1'b0;
        end else if (accept && count_reg == 3'(gi)) begin
          data_reg    <= new_sub;
          present_reg <= 1'b1;
          b_reg       <= block_start;
        end
      end

      assign sub[gi]         = data_reg;
      assign present_vec[gi] = present_reg;
      assign b_vec[gi]       = b_reg;
    end
  endgenerate

  assign header = {b_vec, 4'b0000, 4'b0000, present_vec, 8'h02};

endmodule

// File: tb/tb_audio_sample_packetizer.sv
// Randomized and directed checks of audio_sample_packetizer against a frame-queue model.
module tb_audio_sample_packetizer;

  localparam int SPP = 4;

  logic         clk_pixel = 1'b0;
  logic         reset_n;
  logic [15:0]  audio_sample [2];
  logic         sample_valid;
  logic         sample_ready;
  logic         flush;
  logic [191:0] channel_status;
  logic [23:0]  header;
  logic [55:0]  sub [4];
  logic         packet_valid;
  logic         packet_ready;

  audio_sample_packetizer #(.BIT_WIDTH(16), .SAMPLES_PER_PACKET(SPP)) dut (
    .clk_pixel      (clk_pixel),
    .reset_n        (reset_n),
    .audio_sample   (audio_sample),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .flush          (flush),
    .channel_status (channel_status),
    .header         (header),
    .sub            (sub),
    .packet_valid   (packet_valid),
    .packet_ready   (packet_ready)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [23:0] lf;
    logic [23:0] rf;
    bit          c;
    bit          b;
  } frame_t;

  int           tests_run = 0;
  int           tests_failed = 0;
  bit           mdl_pv;
  int           mdl_fi;
  int           mdl_accepts;
  logic [191:0] mdl_cs;
  frame_t       held[$];
  logic [23:0]  exp_header;
  logic [55:0]  exp_sub [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit even_fix(input logic [23:0] f, input bit c);
    return bit'(($countones(f) + int'(c)) % 2);
  endfunction

  task automatic build_expected();
    exp_header = 24'h000002;
    for (int k = 0; k < 4; k++) exp_sub[k] = '0;
    for (int k = 0; k < held.size(); k++) begin
      frame_t f = held[k];
      exp_header = exp_header | (24'h1 << (8 + k));
      if (f.b) exp_header = exp_header | (24'h1 << (20 + k));
      exp_sub[k] = 56'(f.lf) | (56'(f.rf) << 24)
                 | (56'(f.c) << 50) | (56'(even_fix(f.lf, f.c)) << 51)
                 | (56'(f.c) << 54) | (56'(even_fix(f.rf, f.c)) << 55);
    end
  endtask

  task automatic model_reset();
    mdl_pv = 0;
    mdl_fi = 0;
    mdl_cs = '0;
    held.delete();
  endtask

  // One clock: inputs applied just after the previous edge, model stepped, outputs checked after the edge.
  task automatic cycle(input bit sv, input logic [15:0] l, input logic [15:0] r,
                       input bit fl, input bit pr);
    sample_valid    = sv;
    audio_sample[0] = l;
    audio_sample[1] = r;
    flush           = fl;
    packet_ready    = pr;
    #1;
    check_eq("sample_ready", 64'(sample_ready), 64'(!mdl_pv));
    if (mdl_pv) begin
      if (pr) begin
        mdl_pv = 0;
        held.delete();
      end
    end else begin
      if (sv) begin
        frame_t f;
        if (mdl_fi == 0) mdl_cs = channel_status;
        f.lf = {l, 8'h00};
        f.rf = {r, 8'h00};
        f.c  = (mdl_fi == 0) ? channel_status[0] : mdl_cs[mdl_fi];
        f.b  = (mdl_fi == 0);
        held.push_back(f);
        mdl_fi = (mdl_fi + 1) % 192;
        mdl_accepts++;
      end
      if (held.size() == SPP || (fl && held.size() > 0)) begin
        mdl_pv = 1;
        build_expected();
      end
    end
    @(posedge clk_pixel);
    #1;
    check_eq("packet_valid", 64'(packet_valid), 64'(mdl_pv));
    if (mdl_pv) begin
      check_eq("header", 64'(header), 64'(exp_header));
      for (int k = 0; k < 4; k++) check_eq($sformatf("sub%0d", k), 64'(sub[k]), 64'(exp_sub[k]));
    end
  endtask

  task automatic rand_frame(input bit fl, input bit pr);
    cycle(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), fl, pr);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_packet_valid", 64'(packet_valid), 64'd0);
    check_eq("rst_sample_ready", 64'(sample_ready), 64'd0);
    @(posedge clk_pixel);
    #1;
    check_eq("rst_header", 64'(header), 64'h000002);
    for (int k = 0; k < 4; k++) check_eq("rst_sub", 64'(sub[k]), 64'd0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int pkt;
    reset_n        = 1'b0;
    sample_valid   = 1'b0;
    flush          = 1'b0;
    packet_ready   = 1'b0;
    channel_status = '0;
    audio_sample[0] = '0;
    audio_sample[1] = '0;
    mdl_accepts    = 0;
    model_reset();
    @(posedge clk_pixel);
    #1;
    do_reset();

    // Four-frame packet followed by backpressure and release
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0001, 16'h8000, 1'b0, 1'b0);
    check_eq("four_header", 64'(header), 64'h100F02);
    check_eq("four_left", 64'(sub[0][23:0]), 64'h000100);
    check_eq("four_right", 64'(sub[0][47:24]), 64'h800000);
    check_eq("four_byte6", 64'(sub[0][55:48]), 64'h88);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check_eq("release_ready", 64'(sample_ready), 64'd1);

    // C bit from channel_status bit 1
    do_reset();
    channel_status = 192'h2;
    for (int i = 0; i < 4; i++) rand_frame(1'b0, 1'b0);
    check_eq("c_sub1", 64'({sub[1][54], sub[1][50]}), 64'b11);
    check_eq("c_sub0", 64'({sub[0][54], sub[0][50]}), 64'b00);
    check_eq("c_sub2", 64'({sub[2][54], sub[2][50]}), 64'b00);
    check_eq("c_sub3", 64'({sub[3][54], sub[3][50]}), 64'b00);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    channel_status = '0;

    // Flush with nothing held, then after two frames
    do_reset();
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    check_eq("flush_empty", 64'(packet_valid), 64'd0);
    rand_frame(1'b0, 1'b0);
    rand_frame(1'b0, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    check_eq("flush_header", 64'(header), 64'h100302);
    check_eq("flush_sub23", 64'(sub[2] | sub[3]), 64'd0);
    cycle(1'b1, 16'h1, 16'h1, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Block start across 200 frames with the scheduler always ready
    do_reset();
    mdl_accepts = 0;
    pkt = 0;
    for (int i = 0; i < 400 && mdl_accepts < 200; i++) begin
      rand_frame(1'b0, 1'b1);
      if (mdl_pv) begin
        check_eq($sformatf("hb2_pkt%0d", pkt), 64'(header[23:16]),
                 (pkt == 0 || pkt == 48) ? 64'h10 : 64'h00);
        pkt++;
      end
    end
    check_eq("blk_accepts", 64'(mdl_accepts), 64'd200);

    // Reset mid-packet: while issuing and while collecting
    do_reset();
    for (int i = 0; i < 4; i++) rand_frame(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) rand_frame(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) rand_frame(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) rand_frame(1'b0, 1'b0);
    check_eq("post_reset_hb2", 64'(header[23:16]), 64'h10);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Random traffic with random status words, flushes and backpressure
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (mdl_fi == 0) channel_status = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cycle(bit'($urandom_range(0, 9) < 7), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

endmodule

// File: doc/audio_sample_packetizer.md
# audio_sample_packetizer

- Single-clock stage directly downstream of the audio sample buffer, in the `clk_pixel` domain.
- Takes 2-channel PCM sample frames over a valid/ready handshake and packs up to four frames into one HDMI Audio Sample Packet (layout 0): 24-bit header plus four 56-bit subpackets.
- Inserts IEC 60958 V/U/C/P bits and the 192-frame block-start (B) flags.
- Presents the finished packet to the packet scheduler over a second valid/ready handshake.

## Interface
Parameters:
- BIT_WIDTH, 16: input sample width per channel, legal 16..24.
- SAMPLES_PER_PACKET, 4: frames collected before a packet auto-issues, legal 1..4.

Ports:
- clk_pixel  input  1  sole clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- audio_sample  input  [BIT_WIDTH-1:0] x 2  sample frame; index 0 = left, 1 = right.
- sample_valid  input  1  audio_sample holds a frame.
- sample_ready  output  1  block can accept a frame this cycle.
- flush  input  1  issue a partial packet now if at least 1 frame is held.
- channel_status  input  192  IEC 60958 channel status block, same for both channels.
- header  output  24  packet header, HB0 in [7:0], HB1 in [15:8], HB2 in [23:16].
- sub  output  [55:0] x 4  subpackets 0..3; byte n in bits [8n+7:8n].
- packet_valid  output  1  header and sub hold a complete packet.
- packet_ready  input  1  scheduler consumes the packet this cycle.

## Operation
- **Frame accept:** occurs on a cycle where sample_valid && sample_ready. sample_ready = reset_n && !packet_valid (combinational).
- **Frame count:** count (0..SAMPLES_PER_PACKET) is the number of frames held for the packet being built.
- **Frame index:** frame_index (8 bit, 0..191) numbers the IEC 60958 frame of the next accepted frame. It increments on every accept and wraps 191→0.
- **Subpacket fields:** for a frame accepted into slot k = count:
  - Bytes 0–2, per channel: 24-bit field = {audio_sample, (24-BIT_WIDTH) zeros}, LSB in byte 0. Left uses bytes 0–2, right uses bytes 3–5.
  - Byte 6: bit0 V_L=0, bit1 U_L=0, bit2 C_L, bit3 P_L, bit4 V_R=0, bit5 U_R=0, bit6 C_R, bit7 P_R.
  - C = channel_status[0] when frame_index==0, using the live input. On an accept at frame_index 0 the block latches channel_status into cs_reg. For frame_index>0, C = cs_reg[frame_index].
  - P = XOR of the 24-bit field, V, U and C, so the 28 bits have even parity.
- **B flags:** B[k]=1 iff the frame was accepted at frame_index 0.
- **Header:**
  - HB0 = 8'h02.
  - HB1 = {3'b000, 1'b0 layout, present[3:0]}.
  - HB2 = {B[3:0], 4'b0000 sample_flat}.
  - present[k]=1 for each filled slot.
  - Unfilled subpackets are all-zero; their present and B bits are 0.
- **States:**
  - COLLECT (packet_valid=0) → ISSUE when an accept makes count==SAMPLES_PER_PACKET.
  - COLLECT → ISSUE when flush && count_next>0. count_next includes a frame accepted in the same cycle.
  - flush with count_next==0 is ignored.
  - ISSUE (packet_valid=1, outputs frozen) → COLLECT on packet_ready. On that transition count clears and all slot registers clear.
- **Reset values:** packet_valid=0, sample_ready=0 while reset_n low, header=24'h000002, sub all 0, count=0, frame_index=0, cs_reg=0.

## Timing
- **Issue latency:** packet_valid rises on the clock edge that accepts the completing frame, or the flushing edge. header and sub are valid in that same cycle.
- **Hold:** header and sub stay stable while packet_valid && !packet_ready.
- **Consume:** packet_valid falls on the edge after packet_ready is sampled high. No frame is accepted on that edge (sample_ready was 0), so a new frame can be accepted at the earliest one cycle later.
- **Throughput:** at most SAMPLES_PER_PACKET frames per SAMPLES_PER_PACKET+1 cycles.
- **flush with packet_valid=1:** no effect.
- **reset_n asserted mid-packet:** drops packet_valid immediately (asynchronous) and discards held frames. The first frame after release has frame_index 0.

## Test plan
- **Four-frame packet:** 4 frames, left=16'h0001, right=16'h8000, frame_index 0..3, channel_status=0.
  - header=24'h100F02.
  - sub0 bytes0–2=00 01 00, bytes3–5=00 00 80.
  - sub0 byte6=8'h88 (P_L=1, P_R=1).
- **C bit:** channel_status bit1=1, others 0; send frames 0..3 → sub1 byte6 has bits 2 and 6 set. sub0, sub2, sub3 have C=0.
- **Block start:** stream 200 frames with packet_ready=1.
  - Packet 0 HB2=8'h10.
  - Packets 1..47 HB2=8'h00.
  - Packet 48 HB2=8'h10.
  - frame_index wraps after 191.
- **Flush:** flush after 2 frames → header=24'h100302, sub2=sub3=0. flush at count 0 → packet_valid stays 0.
- **Backpressure:** hold packet_ready=0 for 10 cycles after issue → sample_ready=0, header/sub unchanged. Release → packet_valid falls the next edge, sample_ready rises.
- **Reset:** pulse reset_n low after 3 frames of the second packet.
  - packet_valid=0 immediately.
  - The next packet after 4 frames has HB2=8'h10 and contains only post-reset data.
